// File: rtl/fir_sched_if.sv
// Requester and response channels between fir_sched and its clients.
// The scheduler takes the slave side; requesters and the response consumer take the master side.
interface fir_sched_if #(
  parameter int DataWidth = 32
);
  logic                 req0_valid;
  logic                 req0_ready;
  logic [DataWidth-1:0] req0_x;
  logic                 req1_valid;
  logic                 req1_ready;
  logic [DataWidth-1:0] req1_x;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DataWidth-1:0] rsp_data;
  logic                 rsp_id;
  logic                 rsp_err;

  modport slave (
    input  req0_valid, req0_x, req1_valid, req1_x, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport master (
    output req0_valid, req0_x, req1_valid, req1_x, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );
endinterface

// File: rtl/fir_sched.sv
// Two-requester round-robin front end for a single FIR core with one sample in flight,
// a RUN watchdog, and a shared response channel.
module fir_sched #(
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  fir_sched_if.slave           bus,
  output logic                 fir_start,
  output logic [DataWidth-1:0] fir_x,
  input  logic                 fir_done,
  input  logic                 fir_idle,
  input  logic [DataWidth-1:0] fir_return,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // The abort fires on the RUN cycle whose watchdog value is one below the limit,
  // so a sample gets exactly TimeoutCycles RUN cycles.
  localparam logic [15:0] WdogLast = 16'(TimeoutCycles - 1);

  state_t               state;
  logic [15:0]          wdog;
  logic                 last_grant;
  logic                 id_reg;
  logic [DataWidth-1:0] x_reg;
  logic [DataWidth-1:0] rsp_data_q;
  logic                 rsp_err_q;
  logic                 rsp_valid_q;

  logic                 grant_valid;
  logic                 grant_id;

  // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == IDLE && fir_idle && !ap_rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = ~last_grant;
      end else if (bus.req0_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end else if (bus.req1_valid) begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
    end
  end

  // A grant is only raised for a requester that is valid, so a grant is a handshake.
  assign bus.req0_ready = grant_valid && !grant_id;
  assign bus.req1_ready = grant_valid &&  grant_id;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_id    = id_reg;
  assign fir_x         = x_reg;

  // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      wdog        <= '0;
      last_grant  <= 1'b1;
      id_reg      <= 1'b0;
      x_reg       <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      fir_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            x_reg     <= grant_id ? bus.req1_x : bus.req0_x;
            id_reg    <= grant_id;
            wdog      <= '0;
            fir_start <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // A done arriving on the abort cycle still counts as a normal completion.
          if (fir_done) begin
            rsp_data_q  <= fir_return;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            fir_start   <= 1'b0;
            state       <= RESP;
          end else if (wdog == WdogLast) begin
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            timeout_err <= 1'b1;
            fir_start   <= 1'b0;
            state       <= RESP;
          end else begin
            wdog <= wdog + 16'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            last_grant  <= id_reg;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sched.sv
// Self-checking bench for fir_sched: a behavioural FIR stub plus a response scoreboard.
module tb_fir_sched;
  localparam int DW = 32;
  localparam int TO = 255;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          fir_start;
  logic [DW-1:0] fir_x;
  logic          fir_done = 1'b0;
  logic          fir_idle = 1'b1;
  logic [DW-1:0] fir_return = '0;
  logic          busy;
  logic          timeout_err;

  fir_sched_if #(.DataWidth(DW)) bus ();

  fir_sched #(.DataWidth(DW), .TimeoutCycles(TO)) dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .bus         (bus.slave),
    .fir_start   (fir_start),
    .fir_x       (fir_x),
    .fir_done    (fir_done),
    .fir_idle    (fir_idle),
    .fir_return  (fir_return),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic          id;
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;

  rsp_t sb[$];
  int checks = 0;
  int failures = 0;

  // FIR stub: done on RUN cycle stub_lat (0 = never), result fixed or derived from fir_x.
  int            stub_lat = 4;
  bit            stub_fixed = 1'b0;
  logic [DW-1:0] stub_ret = '0;
  int            run_cnt = 0;

  always @(negedge ap_clk) begin
    if (fir_start === 1'b1) begin
      run_cnt  = run_cnt + 1;
      fir_done = (stub_lat != 0 && run_cnt == stub_lat);
    end else begin
      run_cnt  = 0;
      fir_done = 1'b0;
    end
    fir_idle   = (fir_start !== 1'b1);
    fir_return = stub_fixed ? stub_ret : fir_x * 32'd3 + 32'd7;
  end

  function automatic logic [DW-1:0] model(input logic [DW-1:0] x);
    return x * 32'd3 + 32'd7;
  endfunction

  task automatic step();
    @(negedge ap_clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    ap_rst         = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.rsp_ready  = 1'b0;
    step();
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, fir_start, busy, timeout_err,
         bus.req0_ready, bus.req1_ready} !== 8'b0) begin
      failures++;
      $display("FAIL %s_reset_flags got=%b want=00000000", tag,
               {bus.rsp_valid, bus.rsp_id, bus.rsp_err, fir_start, busy, timeout_err,
                bus.req0_ready, bus.req1_ready});
    end
    checks++;
    if ({bus.rsp_data, fir_x} !== {DW{2'b00}}) begin
      failures++;
      $display("FAIL %s_reset_data got rsp_data=%h fir_x=%h want 0/0", tag, bus.rsp_data, fir_x);
    end
    ap_rst         = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    sb.delete();
    step();
  endtask

  // Present one sample, wait for the grant, push its expected response, and step past the handshake.
  task automatic send(input bit id, input logic [DW-1:0] x, input logic [DW-1:0] exp_data,
                      input bit exp_err, input string tag);
    int n = 0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_x = x; end
    else    begin bus.req0_valid = 1'b1; bus.req0_x = x; end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 8) begin step(); n++; end
    checks++;
    if ((id ? bus.req1_ready : bus.req0_ready) !== 1'b1) begin
      failures++;
      $display("FAIL %s_grant got ready=0 want 1 for requester %0d", tag, id);
    end
    sb.push_back('{id: id, data: exp_data, err: exp_err});
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    checks++;
    if ({fir_start, busy, fir_x} !== {2'b11, x}) begin
      failures++;
      $display("FAIL %s_run_entry got start=%b busy=%b fir_x=%h want 1/1/%h",
               tag, fir_start, busy, fir_x, x);
    end
  endtask

  // Wait for a response, optionally stall it, then compare against the scoreboard and accept it.
  task automatic collect(input int bound, input int hold, input string tag, output int lat);
    int   n = 0;
    rsp_t exp;
    rsp_t got;
    while (bus.rsp_valid !== 1'b1 && n < bound) begin step(); n++; end
    lat = n;
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s_rsp_wait got rsp_valid=%b want 1 within %0d cycles", tag, bus.rsp_valid, bound);
      return;
    end
    got = '{id: bus.rsp_id, data: bus.rsp_data, err: bus.rsp_err};
    if (hold > 0) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        step();
        checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, fir_start,
             bus.req0_ready, bus.req1_ready} !== {1'b1, got.id, got.err, got.data, 3'b000}) begin
          failures++;
          $display("FAIL %s_hold cycle %0d got v=%b id=%b err=%b data=%h start=%b rdy=%b%b want 1/%b/%b/%h/0/00",
                   tag, i, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, fir_start,
                   bus.req0_ready, bus.req1_ready, got.id, got.err, got.data);
        end
      end
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected_rsp got id=%b data=%h err=%b want no response", tag,
               bus.rsp_id, bus.rsp_data, bus.rsp_err);
    end else begin
      exp = sb.pop_front();
      if ({bus.rsp_id, bus.rsp_data, bus.rsp_err} !== {exp.id, exp.data, exp.err}) begin
        failures++;
        $display("FAIL %s_rsp got id=%b data=%h err=%b want id=%b data=%h err=%b", tag,
                 bus.rsp_id, bus.rsp_data, bus.rsp_err, exp.id, exp.data, exp.err);
      end
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset("init");
  endtask

  task automatic test_single();
    int lat;
    stub_lat   = 56;
    stub_fixed = 1'b1;
    stub_ret   = 32'h0000_1234;
    send(1'b0, 32'd5, 32'h0000_1234, 1'b0, "single");
    collect(80, 0, "single", lat);
    checks++;
    if (lat !== 56) begin
      failures++;
      $display("FAIL single_latency got %0d cycles want 56", lat);
    end
    stub_fixed = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] x0 = 32'd100;
    logic [DW-1:0] x1 = 32'd200;
    int lat;
    do_reset("rr");
    stub_lat       = 3;
    bus.req0_x     = x0;
    bus.req1_x     = x1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      int n = 0;
      bit gid;
      bit want = ((i % 2) != 0);
      while (!(bus.req0_ready || bus.req1_ready) && n < 8) begin step(); n++; end
      gid = bus.req1_ready;
      checks++;
      if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1 || gid !== want) begin
        failures++;
        $display("FAIL rr_order grant %0d got ready0=%b ready1=%b want requester %0d",
                 i, bus.req0_ready, bus.req1_ready, want);
      end
      sb.push_back('{id: gid, data: model(gid ? x1 : x0), err: 1'b0});
      step();
      if (gid) begin x1 = x1 + 32'd1; bus.req1_x = x1; end
      else     begin x0 = x0 + 32'd1; bus.req0_x = x0; end
      collect(40, 0, "rr", lat);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_back_pressure();
    int lat;
    stub_lat = 6;
    send(1'b1, 32'd77, model(32'd77), 1'b0, "bp");
    collect(20, 10, "bp", lat);
  endtask

  task automatic test_reset_mid_run();
    int n = 0;
    int lat;
    bit seen = 1'b0;
    stub_lat = 0;
    send(1'b1, 32'd33, model(32'd33), 1'b0, "midrun");
    while (run_cnt != 20 && n < 40) begin step(); n++; end
    checks++;
    if (run_cnt != 20) begin
      failures++;
      $display("FAIL midrun_reach got run cycle %0d want 20", run_cnt);
    end
    do_reset("midrun");
    for (int i = 0; i < 10; i++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL midrun_no_rsp got rsp_valid=1 want 0 after reset");
    end
    stub_lat = 5;
    send(1'b0, 32'd44, model(32'd44), 1'b0, "post_reset");
    collect(20, 0, "post_reset", lat);
  endtask

  task automatic test_coincide();
    int lat;
    do_reset("co");
    stub_lat   = TO;
    stub_fixed = 1'b1;
    stub_ret   = 32'h0000_CAFE;
    send(1'b0, 32'd1, 32'h0000_CAFE, 1'b0, "co");
    collect(300, 0, "co", lat);
    checks++;
    if (lat !== TO || timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL co_edge got lat=%0d timeout_err=%b want %0d/0", lat, timeout_err, TO);
    end
    stub_fixed = 1'b0;
  endtask

  task automatic test_timeout();
    int lat;
    stub_lat = 0;
    send(1'b0, 32'd9, '0, 1'b1, "to");
    collect(300, 0, "to", lat);
    checks++;
    if (lat !== TO || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_abort got lat=%0d timeout_err=%b want %0d/1", lat, timeout_err, TO);
    end
    stub_lat = 4;
    send(1'b1, 32'd11, model(32'd11), 1'b0, "to_after");
    collect(20, 0, "to_after", lat);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_sticky got timeout_err=%b want 1", timeout_err);
    end
    do_reset("to_clear");
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_x     = '0;
    bus.req1_x     = '0;
    bus.rsp_ready  = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_mid_run();
    test_coincide();
    test_timeout();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_sched.md
FIR_SCHED -- requirements
Module: fir_sched

Parameters
REQ-001 SHALL provide DataWidth, default 32, width of sample and result words.
REQ-002 SHALL provide TimeoutCycles, default 255, maximum RUN cycles before abort; legal range 1..65535.

Interface
REQ-003 SHALL have ap_clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have ap_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have req0_valid  input  1, req0_x  input  DataWidth, req0_ready  output  1: requester 0 sample channel.
REQ-006 SHALL have req1_valid  input  1, req1_x  input  DataWidth, req1_ready  output  1: requester 1 sample channel.
REQ-007 SHALL have rsp_valid  output  1, rsp_ready  input  1, rsp_data  output  DataWidth, rsp_id  output  1, rsp_err  output  1: shared response channel.
REQ-008 SHALL have fir_start  output  1, fir_x  output  DataWidth: drive the FIR core start and sample inputs.
REQ-009 SHALL have fir_done  input  1, fir_idle  input  1, fir_return  input  DataWidth: FIR core status and result.
REQ-010 SHALL have busy  output  1 (state != IDLE) and timeout_err  output  1 (sticky abort flag).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, RESP; no other reachable state.
REQ-012 In IDLE with fir_idle=1, SHALL grant one valid requester; when both are valid, SHALL grant the one not in last_grant (round robin).
REQ-013 SHALL assert reqN_ready combinationally only in IDLE, only for the granted requester, only while fir_idle=1; handshake = valid & ready.
REQ-014 On handshake SHALL latch reqN_x into x_reg, N into id_reg, clear the watchdog, and enter RUN next cycle.
REQ-015 SHALL drive fir_x = x_reg, stable from RUN entry until RESP exit.
REQ-016 SHALL drive fir_start = 1 for every RUN cycle and 0 in IDLE and RESP, so the core sees start deasserted on the cycle after fir_done.
REQ-017 In RUN, on fir_done=1, SHALL capture fir_return into rsp_data, set rsp_err=0, and enter RESP next cycle.
REQ-018 In RUN, the watchdog SHALL increment each cycle without fir_done; at count = TimeoutCycles it SHALL set rsp_data=0, rsp_err=1, timeout_err=1, and enter RESP.
REQ-019 If fir_done and the timeout coincide, SHALL treat it as normal completion (REQ-017).
REQ-020 In RESP, SHALL assert rsp_valid=1 with rsp_data, rsp_id=id_reg, and rsp_err held stable until rsp_ready=1.
REQ-021 On rsp_valid & rsp_ready, SHALL set last_grant=id_reg and return to IDLE; the next grant is no earlier than the following cycle.
REQ-022 SHALL ignore fir_done outside RUN.
REQ-023 SHALL hold rsp_valid=1 exactly one cycle after fir_done (latency 1); no internal queuing, at most one outstanding sample.
REQ-024 SHALL clear timeout_err only on ap_rst.

Reset
REQ-025 On ap_rst=1 at a clock edge, SHALL enter IDLE with rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, fir_start=0, fir_x=0, req0_ready/req1_ready=0 during the reset cycle, busy=0, timeout_err=0, watchdog=0, last_grant=1.
REQ-026 A reset asserted mid-RUN or mid-RESP SHALL discard the in-flight sample with no response.

Verification
REQ-027 Single request: req0 x=5, FIR stub asserts done 56 cycles after start with return 0x00001234 -> rsp_valid next cycle with rsp_data=0x00001234, rsp_id=0, rsp_err=0.
REQ-028 Both requesters continuously valid after reset -> grant order 0,1,0,1, each response carries the matching rsp_id.
REQ-029 rsp_ready held low 10 cycles in RESP -> rsp_data, rsp_id, and rsp_err stable; fir_start=0; both req_ready=0.
REQ-030 Stub never asserts done, TimeoutCycles=255 -> RESP after 255 RUN cycles with rsp_err=1, rsp_data=0; timeout_err stays 1 across later good transactions until reset.
REQ-031 Reset asserted on RUN cycle 20 -> all outputs at reset values after the edge; no response for that sample; next request granted normally.
REQ-032 fir_done on the same cycle the watchdog reaches TimeoutCycles -> normal response with rsp_err=0 and timeout_err=0.
